irencoder_wb8: RTL and testbench



---
 rtl/irencoder_wb8.sv | 246 ++++++++++++++++++++++++
 tb/tb_irencoder_wb8.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irencoder_wb8.sv
// irencoder_wb8: Wishbone (8-bit) NEC infrared transmitter.
// The CPU loads a 32-bit frame as four bytes and then requests either a
// full frame or a repeat code. The block produces the NEC mark/space
// envelope and, if enabled, gates a carrier onto the LED drive during marks.
// The pulse durations are parameters in microseconds. Their defaults are the
// NEC timings. They can be shortened for fast simulation.
module irencoder_wb8 #(
    parameter int CLOCKFREQ       = 25000000,
    parameter int CARRIER_HZ      = 38000,
    parameter int CARRIER_EN      = 1,
    parameter int LEAD_MARK_US    = 9000,
    parameter int LEAD_SPACE_US   = 4500,
    parameter int REPEAT_SPACE_US = 2250,
    parameter int BIT_MARK_US     = 563,
    parameter int ZERO_SPACE_US   = 563,
    parameter int ONE_SPACE_US    = 1688,
    parameter int STOP_MARK_US    = 563,
    parameter int GUARD_US        = 10000
) (
    input  logic       I_wb_clk,
    input  logic       I_reset,
    input  logic [2:0] I_wb_adr,
    input  logic       I_wb_stb,
    input  logic       I_wb_we,
    input  logic [7:0] I_wb_dat,
    output logic       O_wb_ack,
    output logic [7:0] O_wb_dat,
    output logic       O_ir_led,
    output logic       O_ir_envelope
);

    localparam int MICROCYCLES = CLOCKFREQ / 1000000;
    localparam int HALF        = CLOCKFREQ / (2 * CARRIER_HZ);

    localparam logic [15:0] PRE_LAST  = 16'(MICROCYCLES - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LEAD_MARK  = 3'd1;
    localparam logic [2:0] ST_LEAD_SPACE = 3'd2;
    localparam logic [2:0] ST_BIT_MARK   = 3'd3;
    localparam logic [2:0] ST_BIT_SPACE  = 3'd4;
    localparam logic [2:0] ST_STOP_MARK  = 3'd5;
    localparam logic [2:0] ST_GUARD      = 3'd6;

    // The envelope is high only in the three mark states.
    function automatic logic is_mark(input logic [2:0] st);
        logic m;
        case (st)
            ST_LEAD_MARK, ST_BIT_MARK, ST_STOP_MARK: m = 1'b1;
            default:                                 m = 1'b0;
        endcase
        return m;
    endfunction

    logic [7:0]  b0_r, b1_r, b2_r, b3_r;
    logic [2:0]  state_r, state_nxt_s;
    logic [31:0] shift_r;
    logic [5:0]  bit_cnt_r;
    logic        repeat_r;
    logic [15:0] pre_r, us_r, dur_s;
    logic        tick_s, end_s, busy_s, state_chg_s;
    logic        wr_s, rd_s, cmd_go_s;
    logic [7:0]  rd_mux_s;
    logic [15:0] car_cnt_r, car_cnt_nxt_s;
    logic        car_r, car_nxt_s, env_nxt_s, led_nxt_s;
    logic        ack_r, env_r, led_r;
    logic [7:0]  dat_r;

    assign busy_s      = (state_r != ST_IDLE);
    assign wr_s        = I_wb_stb & I_wb_we;
    assign rd_s        = I_wb_stb & ~I_wb_we;
    // A command needs at least one send bit, and it is only accepted from IDLE.
    // A write on the cycle GUARD ends still sees busy and is dropped.
    assign cmd_go_s    = wr_s & (I_wb_adr == 3'd4) & ~busy_s & (I_wb_dat[0] | I_wb_dat[1]);
    assign tick_s      = (pre_r == PRE_LAST);
    assign end_s       = tick_s & (us_r == (dur_s - 16'd1));
    assign state_chg_s = (state_nxt_s != state_r);

    // Select the duration in microseconds for the current state.
    always_comb begin
        dur_s = 16'd0;
        case (state_r)
            ST_LEAD_MARK:  dur_s = 16'(LEAD_MARK_US);
            ST_LEAD_SPACE: dur_s = repeat_r ? 16'(REPEAT_SPACE_US) : 16'(LEAD_SPACE_US);
            ST_BIT_MARK:   dur_s = 16'(BIT_MARK_US);
            ST_BIT_SPACE:  dur_s = shift_r[31] ? 16'(ONE_SPACE_US) : 16'(ZERO_SPACE_US);
            ST_STOP_MARK:  dur_s = 16'(STOP_MARK_US);
            ST_GUARD:      dur_s = 16'(GUARD_US);
            default:       dur_s = 16'd0;
        endcase
    end

    // Compute the next NEC sequencer state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_go_s) state_nxt_s = ST_LEAD_MARK;
                else          state_nxt_s = ST_IDLE;
            end
            ST_LEAD_MARK: begin
                if (end_s) state_nxt_s = ST_LEAD_SPACE;
                else       state_nxt_s = ST_LEAD_MARK;
            end
            ST_LEAD_SPACE: begin
                if (end_s) state_nxt_s = repeat_r ? ST_STOP_MARK : ST_BIT_MARK;
                else       state_nxt_s = ST_LEAD_SPACE;
            end
            ST_BIT_MARK: begin
                if (end_s) state_nxt_s = ST_BIT_SPACE;
                else       state_nxt_s = ST_BIT_MARK;
            end
            ST_BIT_SPACE: begin
                if (end_s) state_nxt_s = (bit_cnt_r == 6'd31) ? ST_STOP_MARK : ST_BIT_MARK;
                else       state_nxt_s = ST_BIT_SPACE;
            end
            ST_STOP_MARK: begin
                if (end_s) state_nxt_s = ST_GUARD;
                else       state_nxt_s = ST_STOP_MARK;
            end
            ST_GUARD: begin
                if (end_s) state_nxt_s = ST_IDLE;
                else       state_nxt_s = ST_GUARD;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Compute the next carrier phase. The phase restarts high on every mark entry.
    always_comb begin
        env_nxt_s = is_mark(state_nxt_s);
        if (state_chg_s && env_nxt_s) begin
            car_cnt_nxt_s = 16'd0;
            car_nxt_s     = 1'b1;
        end else if (car_cnt_r == HALF_LAST) begin
            car_cnt_nxt_s = 16'd0;
            car_nxt_s     = ~car_r;
        end else begin
            car_cnt_nxt_s = car_cnt_r + 16'd1;
            car_nxt_s     = car_r;
        end
        if (CARRIER_EN != 0) led_nxt_s = env_nxt_s & car_nxt_s;
        else                 led_nxt_s = env_nxt_s;
    end

    // Build the read-data mux for the register map.
    always_comb begin
        rd_mux_s = 8'h00;
        case (I_wb_adr)
            3'd0:    rd_mux_s = b0_r;
            3'd1:    rd_mux_s = b1_r;
            3'd2:    rd_mux_s = b2_r;
            3'd3:    rd_mux_s = b3_r;
            3'd4:    rd_mux_s = {7'b0000000, busy_s};
            default: rd_mux_s = 8'h00;
        endcase
    end

    // Register the bus response: a single-cycle ack and latched read data.
    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            ack_r <= 1'b0;
            dat_r <= 8'h00;
        end else begin
            ack_r <= I_wb_stb;
            if (rd_s) dat_r <= rd_mux_s;
            else      dat_r <= dat_r;
        end
    end

    // Hold the frame bytes written by the CPU.
    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            b0_r <= 8'h00;
            b1_r <= 8'h00;
            b2_r <= 8'h00;
            b3_r <= 8'h00;
        end else if (wr_s) begin
            case (I_wb_adr)
                3'd0:    b0_r <= I_wb_dat;
                3'd1:    b1_r <= I_wb_dat;
                3'd2:    b2_r <= I_wb_dat;
                3'd3:    b3_r <= I_wb_dat;
                default: b0_r <= b0_r;
            endcase
        end
    end

    // Sequencer state, and the frame snapshot shifted out MSB first.
    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            state_r   <= ST_IDLE;
            shift_r   <= 32'h0000_0000;
            bit_cnt_r <= 6'd0;
            repeat_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (cmd_go_s) begin
                shift_r   <= {b0_r, b1_r, b2_r, b3_r};
                bit_cnt_r <= 6'd0;
                repeat_r  <= ~I_wb_dat[0];
            end else if ((state_r == ST_BIT_SPACE) && end_s) begin
                shift_r   <= {shift_r[30:0], 1'b0};
                bit_cnt_r <= bit_cnt_r + 6'd1;
            end
        end
    end

    // Microsecond timebase; it restarts on every state entry so each state is exact.
    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            pre_r <= 16'd0;
            us_r  <= 16'd0;
        end else if (state_chg_s || (state_r == ST_IDLE)) begin
            pre_r <= 16'd0;
            us_r  <= 16'd0;
        end else if (tick_s) begin
            pre_r <= 16'd0;
            us_r  <= us_r + 16'd1;
        end else begin
            pre_r <= pre_r + 16'd1;
        end
    end

    // Carrier generator and the registered envelope and LED outputs.
    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            car_cnt_r <= 16'd0;
            car_r     <= 1'b0;
            env_r     <= 1'b0;
            led_r     <= 1'b0;
        end else begin
            car_cnt_r <= car_cnt_nxt_s;
            car_r     <= car_nxt_s;
            env_r     <= env_nxt_s;
            led_r     <= led_nxt_s;
        end
    end

    assign O_wb_ack      = ack_r;
    assign O_wb_dat      = dat_r;
    assign O_ir_led      = led_r;
    assign O_ir_envelope = env_r;

endmodule

// File: tb/tb_irencoder_wb8.sv
// Directed bench for irencoder_wb8. It uses shortened pulse durations and a
// 2 MHz clock, so MICROCYCLES is 2. The 250 kHz carrier gives a half-period
// of 4 clocks. A frame is decoded from the envelope runs, the same way
// the IR decoder would see it.
module tb_irencoder_wb8;

    localparam int CF = 2000000;
    localparam int CH = 250000;
    localparam int MC = 2;
    localparam int HALF = 4;
    localparam int LM = 40, LS = 20, RS = 10, BM = 3, ZS = 3, OS = 8, SM = 3, GD = 50;
    localparam int BUDGET = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] adr = 3'd0;
    logic       stb = 1'b0;
    logic       we = 1'b0;
    logic [7:0] wdat = 8'h00;
    wire        ack;
    wire  [7:0] rdat;
    wire        led;
    wire        env;

    int n_checks = 0;
    int n_fail = 0;
    int runs [0:127];
    int n_runs;
    int busy_cyc;
    int led_errs;
    bit timed_out;

    irencoder_wb8 #(
        .CLOCKFREQ(CF), .CARRIER_HZ(CH), .CARRIER_EN(1),
        .LEAD_MARK_US(LM), .LEAD_SPACE_US(LS), .REPEAT_SPACE_US(RS),
        .BIT_MARK_US(BM), .ZERO_SPACE_US(ZS), .ONE_SPACE_US(OS),
        .STOP_MARK_US(SM), .GUARD_US(GD)
    ) dut (
        .I_wb_clk(clk), .I_reset(rst), .I_wb_adr(adr), .I_wb_stb(stb),
        .I_wb_we(we), .I_wb_dat(wdat), .O_wb_ack(ack), .O_wb_dat(rdat),
        .O_ir_led(led), .O_ir_envelope(env)
    );

    always #5 clk = ~clk;

    function automatic int exp_busy_us(input logic [31:0] w, input bit rep);
        int ones;
        ones = $countones(w);
        if (rep) return LM + RS + SM + GD;
        return LM + LS + 32 * BM + ones * OS + (32 - ones) * ZS + SM + GD;
    endfunction

    task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL ack_idle: got %b expected 0", ack); end
        adr = a; we = 1'b1; stb = 1'b1; wdat = d;
        @(posedge clk); #1;
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL ack_pulse: got %b expected 1", ack); end
        @(negedge clk);
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        adr = a; we = 1'b0; stb = 1'b1;
        @(posedge clk); #1;
        d = rdat;
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL ack_read: got %b expected 1", ack); end
        @(negedge clk);
        stb = 1'b0;
    endtask

    task automatic check_read(input logic [2:0] a, input logic [7:0] exp, input string nm);
        logic [7:0] d;
        wb_read(a, d);
        n_checks++;
        if (d !== exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", nm, d, exp); end
    endtask

    task automatic write_frame(input logic [31:0] w);
        wb_write(3'd0, w[31:24]);
        wb_write(3'd1, w[23:16]);
        wb_write(3'd2, w[15:8]);
        wb_write(3'd3, w[7:0]);
    endtask

    // Called at the negedge right after the edge that accepted a command.
    // It records the envelope run lengths, counts busy cycles by polling
    // adr 4 every cycle, and checks the LED against the expected carrier.
    task automatic measure(input int inject_at);
        logic cur, e, l, b, expl;
        int run;
        bit seen;
        n_runs = 0; busy_cyc = 0; led_errs = 0; timed_out = 1'b1;
        stb = 1'b1; we = 1'b0; adr = 3'd4;
        n_checks++;
        if ({env, led} !== 2'b11) begin
            n_fail++; $display("FAIL start_mark: env/led got %b%b expected 11", env, led);
        end
        cur = 1'b1; run = 1; seen = 1'b0;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(negedge clk);
            e = env; l = led; b = rdat[0];
            if (e !== cur) begin
                if (n_runs < 128) runs[n_runs] = run;
                n_runs++;
                cur = e; run = 0;
            end
            expl = e ? (((run / HALF) % 2) == 0) : 1'b0;
            if (l !== expl) led_errs++;
            run++;
            if (b === 1'b1) begin
                busy_cyc++; seen = 1'b1;
            end else if (seen) begin
                timed_out = 1'b0;
                break;
            end
            stb = 1'b1; we = 1'b0; adr = 3'd4; wdat = 8'h00;
            if (cyc == inject_at) begin
                we = 1'b1; adr = 3'd4; wdat = 8'h01;
            end else if (cyc == inject_at + 1) begin
                we = 1'b1; adr = 3'd0; wdat = 8'hAA;
            end
        end
        stb = 1'b0; we = 1'b0;
        n_checks++;
        if (timed_out) begin n_fail++; $display("FAIL busy_timeout: busy never cleared within %0d cycles", BUDGET); end
        n_checks++;
        if (led_errs != 0) begin n_fail++; $display("FAIL carrier: got %0d bad led samples expected 0", led_errs); end
    endtask

    task automatic check_frame(input logic [31:0] w, input bit rep, input string nm);
        int exp_runs, errs;
        logic [31:0] dec;
        exp_runs = rep ? 3 : 67;
        n_checks++;
        if (n_runs != exp_runs) begin
            n_fail++; $display("FAIL %s_runs: got %0d expected %0d", nm, n_runs, exp_runs);
        end else begin
            n_checks++;
            if (runs[0] != LM * MC) begin n_fail++; $display("FAIL %s_lead_mark: got %0d expected %0d", nm, runs[0], LM * MC); end
            n_checks++;
            if (runs[1] != (rep ? RS : LS) * MC) begin
                n_fail++; $display("FAIL %s_lead_space: got %0d expected %0d", nm, runs[1], (rep ? RS : LS) * MC);
            end
            n_checks++;
            if (runs[exp_runs - 1] != SM * MC) begin
                n_fail++; $display("FAIL %s_stop_mark: got %0d expected %0d", nm, runs[exp_runs - 1], SM * MC);
            end
            if (!rep) begin
                errs = 0; dec = 32'h0;
                for (int i = 0; i < 32; i++) begin
                    if (runs[2 + 2 * i] != BM * MC) errs++;
                    if (runs[3 + 2 * i] != (w[31 - i] ? OS : ZS) * MC) errs++;
                    dec = {dec[30:0], (runs[3 + 2 * i] > ((ZS + OS) * MC) / 2)};
                end
                n_checks++;
                if (errs != 0) begin n_fail++; $display("FAIL %s_bit_timing: got %0d bad runs expected 0", nm, errs); end
                n_checks++;
                if (dec !== w) begin n_fail++; $display("FAIL %s_decode: got 0x%08h expected 0x%08h", nm, dec, w); end
            end
        end
        n_checks++;
        if (busy_cyc != exp_busy_us(w, rep) * MC) begin
            n_fail++; $display("FAIL %s_busy: got %0d expected %0d", nm, busy_cyc, exp_busy_us(w, rep) * MC);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if ({ack, rdat, led, env} !== 11'd0) begin
            n_fail++; $display("FAIL reset_outputs: got 0x%03h expected 0x000", {ack, rdat, led, env});
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) check_read(3'(i), 8'h00, "reset_reg");
    endtask

    task automatic test_regs();
        write_frame(32'h11223344);
        wb_write(3'd5, 8'h77);
        check_read(3'd0, 8'h11, "reg_b0");
        check_read(3'd1, 8'h22, "reg_b1");
        check_read(3'd2, 8'h33, "reg_b2");
        check_read(3'd3, 8'h44, "reg_b3");
        check_read(3'd4, 8'h00, "reg_idle_busy");
        check_read(3'd5, 8'h00, "reg_adr5");
        check_read(3'd7, 8'h00, "reg_adr7");
        wb_write(3'd4, 8'h00);
        repeat (4) @(negedge clk);
        n_checks++;
        if (env !== 1'b0) begin n_fail++; $display("FAIL no_cmd_env: got %b expected 0", env); end
        check_read(3'd4, 8'h00, "no_cmd_busy");
    endtask

    task automatic test_frame();
        write_frame(32'h00FF00FF);
        wb_write(3'd4, 8'h01);
        measure(BUDGET * 2);
        check_frame(32'h00FF00FF, 1'b0, "frame");
        n_checks++;
        if ({env, led} !== 2'b00) begin n_fail++; $display("FAIL frame_idle_out: got %b%b expected 00", env, led); end
    endtask

    task automatic test_loopback();
        write_frame(32'h12345678);
        wb_write(3'd4, 8'h01);
        measure(BUDGET * 2);
        check_frame(32'h12345678, 1'b0, "loopback");
    endtask

    task automatic test_repeat();
        wb_write(3'd4, 8'h02);
        measure(BUDGET * 2);
        check_frame(32'h12345678, 1'b1, "repeat");
    endtask

    task automatic test_both_bits();
        write_frame(32'hF0E1D2C3);
        wb_write(3'd4, 8'h03);
        measure(BUDGET * 2);
        check_frame(32'hF0E1D2C3, 1'b0, "both_bits");
    endtask

    task automatic test_busy_ignore();
        write_frame(32'h5A3C0F81);
        wb_write(3'd4, 8'h01);
        measure(30);
        check_frame(32'h5A3C0F81, 1'b0, "inflight");
        check_read(3'd0, 8'hAA, "inflight_b0");
        wb_write(3'd4, 8'h01);
        measure(BUDGET * 2);
        check_frame(32'hAA3C0F81, 1'b0, "after_update");
    endtask

    task automatic test_back_to_back();
        int nb;
        nb = exp_busy_us(32'h0, 1'b1) * MC;
        wb_write(3'd4, 8'h02);
        repeat (nb - 1) @(negedge clk);
        n_checks++;
        if (env !== 1'b0) begin n_fail++; $display("FAIL guard_env: got %b expected 0", env); end
        stb = 1'b1; we = 1'b1; adr = 3'd4; wdat = 8'h02;
        @(negedge clk);
        n_checks++;
        if (env !== 1'b0) begin n_fail++; $display("FAIL guard_end_cmd_ignored: env got %b expected 0", env); end
        @(negedge clk);
        measure(BUDGET * 2);
        check_frame(32'h0, 1'b1, "after_guard");
    endtask

    task automatic test_reset_mid();
        write_frame(32'hC3A55A3C);
        wb_write(3'd4, 8'h01);
        repeat (5) @(negedge clk);
        n_checks++;
        if (env !== 1'b1) begin n_fail++; $display("FAIL mid_env_before: got %b expected 1", env); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({env, led} !== 2'b00) begin n_fail++; $display("FAIL async_reset_out: got %b%b expected 00", env, led); end
        @(negedge clk);
        rst = 1'b0;
        check_read(3'd4, 8'h00, "mid_reset_busy");
        for (int i = 0; i < 4; i++) check_read(3'(i), 8'h00, "mid_reset_data");
        n_checks++;
        if (env !== 1'b0) begin n_fail++; $display("FAIL mid_reset_env_after: got %b expected 0", env); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_frame();
        test_loopback();
        test_repeat();
        test_both_bits();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
